// File: rtl/seg_display_arbiter_if.sv
// Bus between the requesters and the seven-segment display arbiter.
// master: requester side (drives req/data, observes grant and digits).
// slave:  arbiter side.
interface seg_display_arbiter_if;
  logic [2:0]  req;
  logic [15:0] data0;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [2:0]  gnt;
  logic        busy;
  logic [3:0]  segData_1;
  logic [3:0]  segData_2;
  logic [3:0]  segData_3;
  logic [3:0]  segData_4;

  modport master (
    output req, data0, data1, data2,
    input  gnt, busy, segData_1, segData_2, segData_3, segData_4
  );

  modport slave (
    input  req, data0, data1, data2,
    output gnt, busy, segData_1, segData_2, segData_3, segData_4
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one 4-digit seven-segment display between
// three requesters (0 = alarm/status, 1 = score, 2 = timer) with fixed
// priority (req[0] highest) and a minimum hold time per grant.
// Optional feature macro: SEG_DISPLAY_ARBITER_BLINK_EN -- when defined, a
// frozen message (owner released before expiry) blinks with half-period
// BLINK_CYCLES; otherwise it is shown steadily.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES  = 12_500_000,
  parameter int unsigned HOLD_W       = 24,
  parameter int unsigned BLINK_CYCLES = 3_125_000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  seg_display_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  localparam logic [15:0]       BLANK_MSG = 16'hCCCC;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (HOLD_CYCLES < 1 || (64'd1 << HOLD_W) <= 64'(HOLD_CYCLES)) begin : g_bad_hold
    $error("seg_display_arbiter: HOLD_CYCLES must be >= 1 and fit in HOLD_W bits");
  end
  if (BLINK_CYCLES < 1) begin : g_bad_blink
    $error("seg_display_arbiter: BLINK_CYCLES must be >= 1");
  end

  state_e            state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic              busy_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       msg_q, msg_d;

  logic [2:0]        win_oh;
  logic [15:0]       win_data;
  logic [15:0]       own_data;
  logic              owner_req;
  logic              hi_pending;
  logic [15:0]       disp_msg;

  // Fixed-priority winner: lowest asserted index.
  always_comb begin
    win_oh = 3'b000;
    if (bus.req[0])      win_oh = 3'b001;
    else if (bus.req[1]) win_oh = 3'b010;
    else if (bus.req[2]) win_oh = 3'b100;
  end

  // Message of the winner and of the current owner.
  always_comb begin
    case (win_oh)
      3'b010:  win_data = bus.data1;
      3'b100:  win_data = bus.data2;
      default: win_data = bus.data0;
    endcase
    case (gnt_q)
      3'b010:  own_data = bus.data1;
      3'b100:  own_data = bus.data2;
      default: own_data = bus.data0;
    endcase
  end

  assign owner_req  = |(bus.req & gnt_q);
  // For a one-hot grant, gnt_q - 1 masks exactly the higher-priority indices.
  assign hi_pending = |(bus.req & (gnt_q - 3'd1));

  // Next-state, grant, hold counter and message register.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    msg_d   = msg_q;
    case (state_q)
      IDLE: begin
        msg_d = BLANK_MSG;
        if (|bus.req) begin
          state_d = SHOW;
          gnt_d   = win_oh;
          msg_d   = win_data;
          hold_d  = HOLD_LOAD;
        end
      end
      SHOW: begin
        if (hold_q != '0) begin
          // Hold window: no preemption, live update while the owner requests.
          hold_d = hold_q - HOLD_W'(1);
          if (owner_req) msg_d = own_data;
        end else if (hi_pending || (!owner_req && |bus.req)) begin
          // Direct owner-to-owner switch, no IDLE cycle in between.
          gnt_d  = win_oh;
          msg_d  = win_data;
          hold_d = HOLD_LOAD;
        end else if (owner_req) begin
          // Keep the grant; counter saturates at 0 so preemption is
          // re-evaluated every cycle.
          msg_d = own_data;
        end else begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          msg_d   = BLANK_MSG;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        msg_d   = BLANK_MSG;
        hold_d  = '0;
      end
    endcase
  end

  // State, grant, busy, hold counter and message registers.
  // NOTE: sequential state uses non-blocking assignments only, and every
  // register has an asynchronous reset value so the display blanks at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= 3'b000;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      msg_q   <= BLANK_MSG;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= |gnt_d;
      hold_q  <= hold_d;
      msg_q   <= msg_d;
    end
  end

`ifdef SEG_DISPLAY_ARBITER_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_off_q, blink_off_d;
  logic               frozen;

  assign frozen = (state_q == SHOW) && !owner_req && (hold_q != '0);

  // Blink phase: restarts "shown" whenever the message is not frozen or
  // the grant changes, then toggles every BLINK_CYCLES.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (!frozen || (gnt_d != gnt_q)) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_off_d = !blink_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign disp_msg = (blink_off_q && frozen) ? BLANK_MSG : msg_q;
`else
  assign disp_msg = msg_q;
`endif

  // Codes 14 and 15 are not valid glyphs on this display; show them blank.
  function automatic logic [3:0] glyph(input logic [3:0] code);
    return (code >= 4'd14) ? 4'd12 : code;
  endfunction

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.segData_1 = glyph(disp_msg[3:0]);
  assign bus.segData_2 = glyph(disp_msg[7:4]);
  assign bus.segData_3 = glyph(disp_msg[11:8]);
  assign bus.segData_4 = glyph(disp_msg[15:12]);

endmodule
